// File: rtl/knn_topk_engine.sv
// Streaming k-nearest-neighbour engine: 2-stage squared-distance pipeline feeding a
// sorted top-K insertion list, followed by a K-cycle majority vote over the kept labels.
module knn_topk_engine #(
    parameter int COORD_W = 16,
    parameter int LABEL_W = 8,
    parameter int K       = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2*COORD_W-1:0]   test_pt,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*COORD_W-1:0]   in_pt,
    input  logic [LABEL_W-1:0]     in_label,
    input  logic                   in_last,
    output logic                   busy,
    output logic                   done,
    input  logic [IDX_W-1:0]       nb_sel,
    output logic [2*COORD_W:0]     nb_dist,
    output logic [LABEL_W-1:0]     nb_label,
    output logic                   nb_valid,
    output logic [IDX_W:0]         nb_count,
    output logic [LABEL_W-1:0]     vote,
    output logic [2:0]             state_dbg
);
    localparam int DIST_W = 2*COORD_W+1;
    localparam int CW     = COORD_W+1;

    // Handshake: a training point transfers on a rising edge where in_valid and
    // in_ready are both 1; in_ready depends only on state, never on in_valid.
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_VOTE, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   test_x_q, test_y_q;
    logic                 s1_valid_q, s2_valid_q;
    logic [CW-1:0]        s1_dx_q, s1_dy_q;
    logic [LABEL_W-1:0]   s1_label_q, s2_label_q;
    logic [DIST_W-1:0]    s2_dist_q;
    logic [DIST_W-1:0]    ent_dist_q  [K];
    logic [DIST_W-1:0]    ent_dist_d  [K];
    logic [LABEL_W-1:0]   ent_label_q [K];
    logic [LABEL_W-1:0]   ent_label_d [K];
    logic [K-1:0]         ent_valid_q, ent_valid_d;
    logic [IDX_W:0]       count_q, count_d;
    logic [IDX_W-1:0]     vote_i_q;
    logic [IDX_W:0]       best_cnt_q;
    logic [LABEL_W-1:0]   best_label_q, vote_q;

    logic                 start_acc, accept, vote_last, cand_better;
    logic [COORD_W-1:0]   in_x, in_y;
    logic [DIST_W-1:0]    dx_ext, dy_ext, dist_calc;
    logic [IDX_W:0]       ins_pos, match_cnt;

    assign start_acc = (state_q == S_IDLE) && start;
    assign in_ready  = (state_q == S_RUN);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign state_dbg = state_q;
    assign vote      = vote_q;
    assign nb_count  = count_q;
    assign vote_last = (vote_i_q == IDX_W'(K-1));

    assign in_x = in_pt[2*COORD_W-1:COORD_W];
    assign in_y = in_pt[COORD_W-1:0];

    // Squares are taken modulo 2^DIST_W; the true sum always fits, so no signed types are needed.
    assign dx_ext    = {{(DIST_W-CW){s1_dx_q[CW-1]}}, s1_dx_q};
    assign dy_ext    = {{(DIST_W-CW){s1_dy_q[CW-1]}}, s1_dy_q};
    assign dist_calc = dx_ext * dx_ext + dy_ext * dy_ext;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (accept && in_last) state_d = S_DRAIN;
            // When S1 empties, S2 holds the final point and inserts on this edge.
            S_DRAIN: if (!s1_valid_q) state_d = S_VOTE;
            S_VOTE:  if (vote_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Insert position counts occupied entries at or below the new distance (stable ties).
    always_comb begin
        ins_pos = '0;
        for (int e = 0; e < K; e++) begin
            if (ent_valid_q[e] && (ent_dist_q[e] <= s2_dist_q)) ins_pos = ins_pos + 1'b1;
        end
    end

    always_comb begin
        ent_valid_d = ent_valid_q;
        count_d     = count_q;
        for (int e = 0; e < K; e++) begin
            ent_dist_d[e]  = ent_dist_q[e];
            ent_label_d[e] = ent_label_q[e];
        end
        if (start_acc) begin
            ent_valid_d = '0;
            count_d     = '0;
        end else if (s2_valid_q) begin
            if (count_q != (IDX_W+1)'(K)) count_d = count_q + 1'b1;
            if (ins_pos < (IDX_W+1)'(K)) begin
                for (int e = 1; e < K; e++) begin
                    if ((IDX_W+1)'(e) > ins_pos) begin
                        ent_dist_d[e]  = ent_dist_q[e-1];
                        ent_label_d[e] = ent_label_q[e-1];
                        ent_valid_d[e] = ent_valid_q[e-1];
                    end
                end
                for (int e = 0; e < K; e++) begin
                    if ((IDX_W+1)'(e) == ins_pos) begin
                        ent_dist_d[e]  = s2_dist_q;
                        ent_label_d[e] = s2_label_q;
                        ent_valid_d[e] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        match_cnt = '0;
        for (int j = 0; j < K; j++) begin
            if (ent_valid_q[j] && (ent_label_q[j] == ent_label_q[vote_i_q])) match_cnt = match_cnt + 1'b1;
        end
        cand_better = ent_valid_q[vote_i_q] && (match_cnt > best_cnt_q);
    end

    always_comb begin
        nb_valid = 1'b0;
        nb_dist  = '0;
        nb_label = '0;
        if ({1'b0, nb_sel} < (IDX_W+1)'(K)) begin
            nb_valid = ent_valid_q[nb_sel];
            nb_dist  = ent_dist_q[nb_sel];
            nb_label = ent_label_q[nb_sel];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            test_x_q     <= '0;
            test_y_q     <= '0;
            s1_valid_q   <= 1'b0;
            s1_dx_q      <= '0;
            s1_dy_q      <= '0;
            s1_label_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_dist_q    <= '0;
            s2_label_q   <= '0;
            ent_valid_q  <= '0;
            count_q      <= '0;
            vote_i_q     <= '0;
            best_cnt_q   <= '0;
            best_label_q <= '0;
            vote_q       <= '0;
            for (int e = 0; e < K; e++) begin
                ent_dist_q[e]  <= '0;
                ent_label_q[e] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                test_x_q <= test_pt[2*COORD_W-1:COORD_W];
                test_y_q <= test_pt[COORD_W-1:0];
            end
            s1_valid_q <= accept;
            if (accept) begin
                s1_dx_q    <= {in_x[COORD_W-1], in_x} - {test_x_q[COORD_W-1], test_x_q};
                s1_dy_q    <= {in_y[COORD_W-1], in_y} - {test_y_q[COORD_W-1], test_y_q};
                s1_label_q <= in_label;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_dist_q  <= dist_calc;
                s2_label_q <= s1_label_q;
            end
            ent_valid_q <= ent_valid_d;
            count_q     <= count_d;
            for (int e = 0; e < K; e++) begin
                ent_dist_q[e]  <= ent_dist_d[e];
                ent_label_q[e] <= ent_label_d[e];
            end
            if (state_q == S_DRAIN) begin
                vote_i_q     <= '0;
                best_cnt_q   <= '0;
                best_label_q <= '0;
            end else if (state_q == S_VOTE) begin
                vote_i_q <= vote_i_q + 1'b1;
                if (cand_better) begin
                    best_cnt_q   <= match_cnt;
                    best_label_q <= ent_label_q[vote_i_q];
                end
                if (vote_last) vote_q <= cand_better ? ent_label_q[vote_i_q] : best_label_q;
            end
        end
    end
endmodule

// File: tb/tb_knn_topk_engine.sv
// Directed bench for knn_topk_engine: table of hand-computed runs plus stall, reset
// and back-to-back sequences checked against a small sort-based reference.
module tb_knn_topk_engine;
    localparam int COORD_W = 16;
    localparam int LABEL_W = 8;
    localparam int K       = 4;
    localparam int IDX_W   = 2;
    localparam int DIST_W  = 2*COORD_W+1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [2*COORD_W-1:0] test_pt;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*COORD_W-1:0] in_pt;
    logic [LABEL_W-1:0]   in_label;
    logic                 in_last;
    logic                 busy;
    logic                 done;
    logic [IDX_W-1:0]     nb_sel;
    logic [DIST_W-1:0]    nb_dist;
    logic [LABEL_W-1:0]   nb_label;
    logic                 nb_valid;
    logic [IDX_W:0]       nb_count;
    logic [LABEL_W-1:0]   vote;
    logic [2:0]           state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    knn_topk_engine #(.COORD_W(COORD_W), .LABEL_W(LABEL_W), .K(K), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .test_pt(test_pt),
        .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_label(in_label),
        .in_last(in_last), .busy(busy), .done(done), .nb_sel(nb_sel), .nb_dist(nb_dist),
        .nb_label(nb_label), .nb_valid(nb_valid), .nb_count(nb_count), .vote(vote),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0]        tx;
        logic [15:0]        ty;
        logic [3:0]         n;
        logic [9:0][15:0]   px;
        logic [9:0][15:0]   py;
        logic [9:0][7:0]    pl;
        logic [2:0]         exp_n;
        logic [3:0][32:0]   exp_d;
        logic [3:0][7:0]    exp_l;
        logic [7:0]         exp_vote;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic vec_t add_pt(input vec_t v, input int x, input int y, input int l);
        v.px[v.n] = 16'(x);
        v.py[v.n] = 16'(y);
        v.pl[v.n] = 8'(l);
        v.n = v.n + 4'd1;
        return v;
    endfunction

    task automatic do_start(input logic [15:0] tx, input logic [15:0] ty);
        @(negedge clk);
        start   = 1'b1;
        test_pt = {tx, ty};
        @(negedge clk);
        start   = 1'b0;
        test_pt = '0;
    endtask

    // Returns at the negedge after the point transfers; acc_cyc is the accept cycle.
    task automatic send_pt(input logic [15:0] x, input logic [15:0] y, input logic [7:0] l,
                           input logic last, output int acc_cyc);
        int waits = 0;
        in_valid = 1'b1;
        in_pt    = {x, y};
        in_label = l;
        in_last  = last;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) timeout_fail("accept");
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int acc_cyc, input string tag);
        int w = 0;
        check({tag, " ready_drop"}, 64'(in_ready), 64'd0);
        while (!done && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!done) timeout_fail({tag, " done"});
        else begin
            check({tag, " done_lat"}, 64'(cyc - acc_cyc), 64'(K + 3));
            @(negedge clk);
            check({tag, " done_pulse"}, 64'({done, busy}), 64'd0);
        end
    endtask

    task automatic check_results(input int exp_n, input logic [3:0][32:0] exp_d,
                                 input logic [3:0][7:0] exp_l, input logic [7:0] exp_vote,
                                 input string tag);
        for (int s = 0; s < K; s++) begin
            nb_sel = IDX_W'(s);
            #1;
            check($sformatf("%s valid%0d", tag, s), 64'(nb_valid), 64'(s < exp_n));
            if (s < exp_n) begin
                check($sformatf("%s dist%0d", tag, s), 64'(nb_dist), 64'(exp_d[s]));
                check($sformatf("%s label%0d", tag, s), 64'(nb_label), 64'(exp_l[s]));
            end
        end
        check({tag, " count"}, 64'(nb_count), 64'(exp_n));
        check({tag, " vote"}, 64'(vote), 64'(exp_vote));
    endtask

    task automatic run_vec(input vec_t v, input int prev_n, input string tag);
        int acc;
        if (prev_n >= 0) check({tag, " prev_count"}, 64'(nb_count), 64'(prev_n));
        do_start(v.tx, v.ty);
        nb_sel = '0;
        #1;
        check({tag, " cleared"}, 64'({nb_count, nb_valid}), 64'd0);
        for (int i = 0; i < int'(v.n); i++) send_pt(v.px[i], v.py[i], v.pl[i], (i == int'(v.n) - 1), acc);
        wait_done(acc, tag);
        check_results(int'(v.exp_n), v.exp_d, v.exp_l, v.exp_vote, tag);
    endtask

    task automatic run_stress();
        int mx[10], my[10], ml[10];
        longint md[10];
        bit used[10];
        int tx, ty, acc, best, bc, cnt;
        logic [3:0][32:0] ed;
        logic [3:0][7:0]  el;
        logic [7:0]       ev;
        tx = $urandom_range(0, 20) - 10;
        ty = $urandom_range(0, 20) - 10;
        for (int i = 0; i < 10; i++) begin
            mx[i] = $urandom_range(0, 40) - 20;
            my[i] = $urandom_range(0, 40) - 20;
            ml[i] = $urandom_range(0, 3);
            md[i] = longint'((mx[i] - tx) * (mx[i] - tx) + (my[i] - ty) * (my[i] - ty));
            used[i] = 1'b0;
        end
        do_start(16'(tx), 16'(ty));
        for (int i = 0; i < 10; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            if (i == 4) begin
                check("stress busy", 64'(busy), 64'd1);
                start   = 1'b1;
                test_pt = {16'sd500, -16'sd500};
                @(negedge clk);
                start   = 1'b0;
                test_pt = '0;
            end
            send_pt(16'(mx[i]), 16'(my[i]), 8'(ml[i]), (i == 9), acc);
        end
        wait_done(acc, "stress");
        // Reference: stable selection of the K smallest distances, then label majority.
        for (int r = 0; r < K; r++) begin
            best = -1;
            for (int i = 0; i < 10; i++)
                if (!used[i] && (best < 0 || md[i] < md[best])) best = i;
            used[best] = 1'b1;
            ed[r] = 33'(md[best]);
            el[r] = 8'(ml[best]);
        end
        bc = 0;
        ev = '0;
        for (int i = 0; i < K; i++) begin
            cnt = 0;
            for (int j = 0; j < K; j++) if (el[j] == el[i]) cnt++;
            if (cnt > bc) begin
                bc = cnt;
                ev = el[i];
            end
        end
        check_results(K, ed, el, ev, "stress");
    endtask

    initial begin
        vecs[0] = '0;
        vecs[0] = add_pt(vecs[0], 3, 4, 1);
        vecs[0] = add_pt(vecs[0], 1, 1, 2);
        vecs[0] = add_pt(vecs[0], -2, 0, 2);
        vecs[0] = add_pt(vecs[0], 0, 5, 1);
        vecs[0] = add_pt(vecs[0], 10, 10, 3);
        vecs[0].exp_n = 3'd4;
        vecs[0].exp_d = {33'd25, 33'd25, 33'd4, 33'd2};
        vecs[0].exp_l = {8'd1, 8'd1, 8'd2, 8'd2};
        vecs[0].exp_vote = 8'd2;

        vecs[1] = '0;
        vecs[1] = add_pt(vecs[1], 5, 0, 7);
        vecs[1] = add_pt(vecs[1], 0, 1, 9);
        vecs[1].exp_n = 3'd2;
        vecs[1].exp_d = {33'd0, 33'd0, 33'd25, 33'd1};
        vecs[1].exp_l = {8'd0, 8'd0, 8'd7, 8'd9};
        vecs[1].exp_vote = 8'd9;

        vecs[2] = '0;
        vecs[2].tx = 16'h8000;
        vecs[2].ty = 16'h8000;
        vecs[2] = add_pt(vecs[2], 32767, 32767, 5);
        vecs[2].exp_n = 3'd1;
        vecs[2].exp_d = {33'd0, 33'd0, 33'd0, 33'd8589672450};
        vecs[2].exp_l = {8'd0, 8'd0, 8'd0, 8'd5};
        vecs[2].exp_vote = 8'd5;

        vecs[3] = '0;
        vecs[3].tx = 16'd1;
        vecs[3].ty = 16'd1;
        vecs[3] = add_pt(vecs[3], 1, 2, 4);
        vecs[3] = add_pt(vecs[3], 4, 5, 6);
        vecs[3] = add_pt(vecs[3], 1, 0, 4);
        vecs[3] = add_pt(vecs[3], 2, 2, 6);
        vecs[3] = add_pt(vecs[3], 1, 1, 8);
        vecs[3].exp_n = 3'd4;
        vecs[3].exp_d = {33'd2, 33'd1, 33'd1, 33'd0};
        vecs[3].exp_l = {8'd6, 8'd4, 8'd4, 8'd8};
        vecs[3].exp_vote = 8'd4;

        rst = 1'b0;
        start = 1'b0;
        test_pt = '0;
        in_valid = 1'b0;
        in_pt = '0;
        in_label = '0;
        in_last = 1'b0;
        nb_sel = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset outs", 64'({in_ready, busy, done}), 64'd0);
        check("reset count", 64'(nb_count), 64'd0);
        check("reset vote", 64'(vote), 64'd0);
        check("reset valid0", 64'(nb_valid), 64'd0);

        run_vec(vecs[0], -1, "v0");
        run_vec(vecs[1], 4, "v1");
        run_vec(vecs[2], 2, "v2");
        run_vec(vecs[3], 1, "v3");
        run_stress();

        begin
            int acc;
            do_start(16'd0, 16'd0);
            send_pt(16'd3, 16'd4, 8'd1, 1'b0, acc);
            send_pt(16'd1, 16'd1, 8'd2, 1'b0, acc);
            #2;
            rst = 1'b0;
            #1;
            check("midrst outs", 64'({in_ready, busy, done}), 64'd0);
            check("midrst count", 64'(nb_count), 64'd0);
            @(negedge clk);
            rst = 1'b1;
        end
        run_vec(vecs[1], 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/knn_topk_engine.md
Name: knn_topk_engine

Overview:
- Streaming k-nearest-neighbour engine, next generation of the single-pair distance core.
- Holds one test point, accepts a stream of labelled 2-D training points over a valid/ready handshake, and computes squared Euclidean distance in a 2-stage pipeline.
- Maintains a sorted top-K list by insertion, then produces a majority-vote label.
- Sits behind the KNN peripheral register file; software reads results through an indexed read port.

Parameters:
- COORD_W, 16, width of each signed coordinate; point packing is x = pt[2*COORD_W-1:COORD_W], y = pt[COORD_W-1:0]
- LABEL_W, 8, width of a training-point class label
- K, 4, number of neighbours kept (K >= 1)
- IDX_W, 2, width of the neighbour select index (2^IDX_W >= K)
- DIST_W (localparam), 2*COORD_W+1, distance width; holds the max value 2*(2^COORD_W-1)^2 without overflow

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; ignored unless state is IDLE
- test_pt  in  2*COORD_W  test point, sampled on accepted start
- in_valid  in  1  training point valid
- in_ready  out  1  engine accepts a point this cycle
- in_pt  in  2*COORD_W  training point
- in_label  in  LABEL_W  training label
- in_last  in  1  marks the final point of the stream; qualified by handshake
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when results are final
- nb_sel  in  IDX_W  neighbour read index; 0 is the nearest
- nb_dist  out  DIST_W  distance of entry nb_sel (combinational read)
- nb_label  out  LABEL_W  label of entry nb_sel
- nb_valid  out  1  entry nb_sel is occupied; 0 when nb_sel >= K
- nb_count  out  IDX_W+1  number of occupied entries, saturates at K
- vote  out  LABEL_W  majority label, valid from done until the next start

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; in_ready, busy, done = 0.
  - All entry valids, nb_count and vote = 0; pipeline valids cleared.
  - Reset mid-run abandons the run entirely.
- FSM states: IDLE -> RUN -> DRAIN -> VOTE -> DONE -> IDLE.
- IDLE:
  - in_ready = 0.
  - start latches test_pt, clears all entry valids and nb_count, then goes to RUN.
  - Results of the previous run stay readable until start.
- RUN:
  - in_ready = 1; a point is accepted when in_valid & in_ready.
  - Accepting a point with in_last = 1 moves to DRAIN the next cycle; in_ready is 0 from then on.
  - start is ignored in every non-IDLE state.
- Pipeline:
  - S1 registers dx = x_in - x_t and dy = y_in - y_t, each sign-extended to COORD_W+1 bits, plus the label.
  - S2 registers d = dx*dx + dy*dy (unsigned, DIST_W bits) plus the label.
  - The insert happens in the cycle after S2 is valid.
  - A point accepted at cycle t is visible in the list at t+3.
  - Throughput is one point per cycle with no stalls.
- Insert rule:
  - Unoccupied entries compare as +infinity.
  - Position p = number of occupied entries with dist <= d, so ties keep the earlier arrival nearer.
  - Entries p..K-2 shift to p+1; entry K-1 is dropped.
  - If p == K, the point is discarded.
  - nb_count increments, saturating at K.
- DRAIN: wait until S1 and S2 are empty and the final insert is done (3 cycles after the last accept), then go to VOTE.
- VOTE:
  - Runs exactly K cycles, with i = 0..K-1.
  - If entry i is occupied, count the occupied entries j with label[j] == label[i].
  - Replace best when count > best_count (strict), so ties go to the candidate with the nearer neighbour.
  - After the K cycles, vote = best label, then go to DONE.
  - With zero occupied entries, vote = 0. This cannot happen in a legal run, because in_last always carries a point.
- DONE: done = 1 for one cycle, then IDLE.
- The list, nb_count and vote are frozen until the next start.

Test Plan:
- K=4, test (0,0); stream (3,4)L1, (1,1)L2, (-2,0)L2, (0,5)L1, (10,10)L3 [last] -> list dist 2/L2, 4/L2, 25/L1(3,4), 25/L1(0,5); 200 dropped; nb_count=4; vote=2 (1-vs-2 tie broken by the nearest neighbour); done exactly K+3 cycles after the last accept.
- Two points (5,0)L7, (0,1)L9 [last] with test (0,0) -> entries 1/L9, 25/L7; nb_valid=0 for sel 2,3; nb_count=2; vote=9.
- Extreme coords: test (-32768,-32768), point (32767,32767) -> nb_dist = 2*65535^2 = 8589672450, no overflow.
- Stall stress: in_valid toggles randomly and in_last comes with the 10th point -> results match the reference model; in_ready drops the cycle after the last accept; start pulses while busy are ignored.
- Reset asserted mid-RUN -> in_ready, busy, done, nb_count = 0 immediately (asynchronous); a new start runs cleanly.
- Back-to-back runs: a second start after done -> first-run results are readable until start and fully cleared after it.
